// File: rtl/e32_arb_pkg.sv
// Shared types for the E32 memory port arbiter.
// Imported by arb_pick and mem_port_arbiter.
package e32_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_WAIT,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        REQ_IF,
        REQ_LS
    } arb_req_t;

    localparam int ARB_LAT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Winner select between IF and LS requesters.
// ARB_ROUND_ROBIN_EN: ties go to the side not last granted; else LS wins ties.
import e32_arb_pkg::*;

module arb_pick (
    input  logic i_if_req,
    input  logic i_ls_req,
    input  logic i_last,
    output logic o_win
);

    arb_req_t w_win;

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        w_win = REQ_IF;
        if (i_if_req && i_ls_req)
            w_win = (arb_req_t'(i_last) == REQ_LS) ? REQ_IF : REQ_LS;
        else if (i_ls_req)
            w_win = REQ_LS;
    end
`else
    logic w_unused_last;
    assign w_unused_last = i_last;

    always_comb begin
        w_win = i_ls_req ? REQ_LS : REQ_IF;
    end
`endif

    assign o_win = w_win;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and load/store.
// ARB_ROUND_ROBIN_EN (in arb_pick) selects round-robin instead of LS-priority ties.
import e32_arb_pkg::*;

module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              busy
);

    localparam logic [ARB_LAT_W-1:0] LAT_LOAD = ARB_LAT_W'(MEM_LATENCY - 1);

    arb_state_t            r_state;
    arb_req_t              r_win;
    arb_req_t              r_last;
    logic                  r_we;
    logic [ARB_LAT_W-1:0]  r_cnt;
    logic                  r_if_gnt;
    logic                  r_ls_gnt;
    logic                  r_if_rvalid;
    logic                  r_ls_rvalid;
    logic [DATA_W-1:0]     r_if_rdata;
    logic [DATA_W-1:0]     r_ls_rdata;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [DATA_W-1:0]     r_mem_data_o;
    logic                  r_mem_write;

    logic     w_win_raw;
    arb_req_t w_win;
    logic     w_go;

    arb_pick u_pick (
        .i_if_req (if_req),
        .i_ls_req (ls_req),
        .i_last   (r_last),
        .o_win    (w_win_raw)
    );

    assign w_win = arb_req_t'(w_win_raw);
    assign w_go  = enable && (if_req || ls_req);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ARB_IDLE;
            r_win        <= REQ_LS;
            r_last       <= REQ_LS;
            r_we         <= 1'b0;
            r_cnt        <= '0;
            r_if_gnt     <= 1'b0;
            r_ls_gnt     <= 1'b0;
            r_if_rvalid  <= 1'b0;
            r_ls_rvalid  <= 1'b0;
            r_if_rdata   <= '0;
            r_ls_rdata   <= '0;
            r_mem_addr   <= '0;
            r_mem_data_o <= '0;
            r_mem_write  <= 1'b0;
        end else begin
            r_if_gnt     <= 1'b0;
            r_ls_gnt     <= 1'b0;
            r_if_rvalid  <= 1'b0;
            r_ls_rvalid  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_data_o <= '0;
            unique case (r_state)
                ARB_IDLE, ARB_RESP: begin
                    if (w_go) begin
                        r_state <= ARB_ADDR;
                        r_win   <= w_win;
                        r_last  <= w_win;
                        if (w_win == REQ_LS) begin
                            r_ls_gnt     <= 1'b1;
                            r_mem_addr   <= ls_addr;
                            r_we         <= ls_we;
                            r_mem_write  <= ls_we;
                            r_mem_data_o <= ls_we ? ls_wdata : '0;
                        end else begin
                            r_if_gnt   <= 1'b1;
                            r_mem_addr <= if_addr;
                            r_we       <= 1'b0;
                        end
                    end else begin
                        r_state    <= ARB_IDLE;
                        r_mem_addr <= '0;
                    end
                end
                ARB_ADDR: begin
                    r_cnt <= LAT_LOAD;
                    if (r_we) begin
                        r_state    <= ARB_IDLE;
                        r_mem_addr <= '0;
                    end else begin
                        r_state <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    // last wait cycle is the one where mem_data_i is valid
                    if (r_cnt == '0) begin
                        r_state    <= ARB_RESP;
                        r_mem_addr <= '0;
                        if (r_win == REQ_LS) begin
                            r_ls_rvalid <= 1'b1;
                            r_ls_rdata  <= mem_data_i;
                        end else begin
                            r_if_rvalid <= 1'b1;
                            r_if_rdata  <= mem_data_i;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign if_gnt     = r_if_gnt;
    assign ls_gnt     = r_ls_gnt;
    assign if_rvalid  = r_if_rvalid;
    assign ls_rvalid  = r_ls_rvalid;
    assign if_rdata   = r_if_rdata;
    assign ls_rdata   = r_ls_rdata;
    assign mem_addr   = r_mem_addr;
    assign mem_data_o = r_mem_data_o;
    assign mem_write  = r_mem_write;
    assign busy       = (r_state != ARB_IDLE);

endmodule
